i2c_24cxx_master: RTL and testbench

//  I2C initiator issuing single-byte reads/writes to a 24Cxx serial EEPROM on the cart bus.

---
 rtl/i2c_24cxx_master.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_i2c_24cxx_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_24cxx_master.sv
// I2C initiator for single-byte 24Cxx EEPROM reads/writes (X24C01, 24C02-16, 24C32+).
// Define I2C_ACK_POLL_EN to add post-write ACK polling before done.
`timescale 1ns/1ps
module i2c_24cxx_master #(
    parameter int CLK_DIV  = 8,
    parameter int POLL_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic        req,
    input  logic        we,
    input  logic [12:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        done,
    output logic        nack_err,
    output logic        scl_o,
    output logic        sda_o,
    input  logic        sda_i
);
    if (CLK_DIV < 2 || CLK_DIV > 255 || POLL_MAX < 1 || POLL_MAX > 255) begin : g_bad_param
        $error("i2c_24cxx_master: parameter out of range");
    end

    typedef enum logic [3:0] {
        IDLE, START, DEV, WADDR_H, WADDR_L, RSTART, DEV_RD,
        WDATA, RDATA, MNACK, STOP,
`ifdef I2C_ACK_POLL_EN
        POLL,
`endif
        FIN
    } state_t;

    state_t      state_q, state_d, next_st;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [3:0]  bitn_q, bitn_d;
    logic [1:0]  mode_q, mode_d;
    logic        we_q, we_d;
    logic [12:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        samp_q, samp_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        nack_q, nack_d;
    logic        scl_q, scl_d;
    logic        sda_q, sda_d;
`ifdef I2C_ACK_POLL_EN
    logic        poll_q, poll_d;
    logic        pnack_q, pnack_d;
    logic [7:0]  pcnt_q, pcnt_d;
`endif
    logic        tick, last_bit, ack_slot, tx_bit, fin;
    logic [7:0]  tx_byte;

    always_comb begin
        tx_byte = wdata_q;
        unique case (state_q)
            DEV:     tx_byte = (mode_q == 2'd0) ? {addr_q[6:0], ~we_q}
                             : {4'hA, (mode_q == 2'd1) ? addr_q[10:8] : 3'b000, 1'b0};
            DEV_RD:  tx_byte = {4'hA, (mode_q == 2'd1) ? addr_q[10:8] : 3'b000, 1'b1};
            WADDR_H: tx_byte = {3'b000, addr_q[12:8]};
            WADDR_L: tx_byte = addr_q[7:0];
            default: tx_byte = wdata_q;
        endcase
    end

    always_comb begin
        next_st = STOP;
        unique case (state_q)
            DEV:     if (mode_q == 2'd0) next_st = we_q ? WDATA : RDATA;
                     else next_st = (mode_q == 2'd1) ? WADDR_L : WADDR_H;
            WADDR_H: next_st = WADDR_L;
            WADDR_L: next_st = we_q ? WDATA : RSTART;
            DEV_RD:  next_st = RDATA;
            RDATA:   next_st = MNACK;
            default: next_st = STOP;
        endcase
    end

    // Read bits and the master NACK slot leave SDA released
    assign ack_slot = (state_q != RDATA) && (state_q != MNACK);
    assign last_bit = (state_q == RDATA) ? (bitn_q == 4'd7)
                    : (state_q == MNACK) ? 1'b1 : (bitn_q == 4'd8);
    assign tx_bit   = (!ack_slot || bitn_q[3]) ? 1'b1 : tx_byte[3'd7 - bitn_q[2:0]];
    assign tick     = busy_q && (cnt_q == 8'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = busy_q ? (tick ? 8'd0 : cnt_q + 8'd1) : 8'd0;
        qtr_d   = qtr_q;
        bitn_d  = bitn_q;
        mode_d  = mode_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        shift_d = shift_q;
        rdata_d = rdata_q;
        samp_d  = samp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        nack_d  = nack_q;
        scl_d   = scl_q;
        sda_d   = sda_q;
        fin     = 1'b0;
`ifdef I2C_ACK_POLL_EN
        poll_d  = poll_q;
        pnack_d = pnack_q;
        pcnt_d  = pcnt_q;
`endif
        if (!busy_q) begin
            if (state_q == FIN) state_d = IDLE;
            if (req) begin
                mode_d  = (mode == 2'd3) ? 2'd2 : mode;
                we_d    = we;
                addr_d  = addr;
                wdata_d = wdata;
                busy_d  = 1'b1;
                nack_d  = 1'b0;
                qtr_d   = 2'd0;
                state_d = START;
`ifdef I2C_ACK_POLL_EN
                poll_d  = 1'b0;
`endif
            end
        end else if (tick) begin
            unique case (state_q)
                START: begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd0) sda_d = 1'b0;
                    else begin
                        scl_d   = 1'b0;
                        qtr_d   = 2'd0;
                        bitn_d  = 4'd0;
                        state_d = DEV;
                    end
                end
                RSTART: begin
                    qtr_d = qtr_q + 2'd1;
                    unique case (qtr_q)
                        2'd0: sda_d = 1'b1;
                        2'd1: scl_d = 1'b1;
                        2'd2: sda_d = 1'b0;
                        2'd3: begin
                            scl_d   = 1'b0;
                            bitn_d  = 4'd0;
                            state_d = DEV_RD;
                        end
                    endcase
                end
                DEV, WADDR_H, WADDR_L, DEV_RD, WDATA, RDATA, MNACK: begin
                    qtr_d = qtr_q + 2'd1;
                    unique case (qtr_q)
                        2'd0: begin
                            scl_d = 1'b0;
                            sda_d = tx_bit;
                        end
                        2'd1: scl_d = 1'b1;
                        2'd2: begin
                            samp_d = sda_i;
                            if (state_q == RDATA) shift_d = {shift_q[6:0], sda_i};
                        end
                        2'd3: begin
                            scl_d  = 1'b0;
                            bitn_d = bitn_q + 4'd1;
                            if (last_bit) begin
                                bitn_d  = 4'd0;
                                state_d = next_st;
`ifdef I2C_ACK_POLL_EN
                                if (poll_q) begin
                                    pnack_d = samp_q;
                                    state_d = STOP;
                                end else
`endif
                                if (ack_slot && samp_q) begin
                                    nack_d  = 1'b1;
                                    state_d = STOP;
                                end
                            end
                        end
                    endcase
                end
                STOP: begin
                    qtr_d = qtr_q + 2'd1;
                    unique case (qtr_q)
                        2'd0: sda_d = 1'b0;
                        2'd1: scl_d = 1'b1;
                        2'd2: sda_d = 1'b1;
                        2'd3: begin
`ifdef I2C_ACK_POLL_EN
                            if (poll_q) begin
                                if (!pnack_q) fin = 1'b1;
                                else if (pcnt_q == 8'(POLL_MAX - 1)) begin
                                    nack_d = 1'b1;
                                    fin    = 1'b1;
                                end else begin
                                    pcnt_d  = pcnt_q + 8'd1;
                                    state_d = POLL;
                                end
                            end else if (we_q && !nack_q) begin
                                poll_d  = 1'b1;
                                pcnt_d  = 8'd0;
                                state_d = POLL;
                            end else fin = 1'b1;
`else
                            fin = 1'b1;
`endif
                        end
                    endcase
                end
`ifdef I2C_ACK_POLL_EN
                POLL: begin
                    qtr_d   = 2'd0;
                    state_d = START;
                end
`endif
                default: state_d = state_q;
            endcase
        end
        if (fin) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (!we_q) rdata_d = shift_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            qtr_q   <= '0;
            bitn_q  <= '0;
            mode_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            shift_q <= '0;
            rdata_q <= '0;
            samp_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
`ifdef I2C_ACK_POLL_EN
            poll_q  <= 1'b0;
            pnack_q <= 1'b0;
            pcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qtr_q   <= qtr_d;
            bitn_q  <= bitn_d;
            mode_q  <= mode_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            shift_q <= shift_d;
            rdata_q <= rdata_d;
            samp_q  <= samp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            nack_q  <= nack_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
`ifdef I2C_ACK_POLL_EN
            poll_q  <= poll_d;
            pnack_q <= pnack_d;
            pcnt_q  <= pcnt_d;
`endif
        end
    end

    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign nack_err = nack_q;
    assign scl_o    = scl_q;
    assign sda_o    = sda_q;
endmodule

// File: tb/tb_i2c_24cxx_master.sv
// Directed bench for i2c_24cxx_master with a behavioural 24Cxx slave on the bus.
// Poll-specific steps build only when I2C_ACK_POLL_EN is defined.
`timescale 1ns/1ps
module tb_i2c_24cxx_master;
    localparam int CLK_DIV = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [12:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        busy, done, nack_err, scl_o, sda_o, sda_i;
    logic        slv_sda = 1'b1;

    assign sda_i = sda_o & slv_sda;

    i2c_24cxx_master #(.CLK_DIV(CLK_DIV), .POLL_MAX(255)) dut (
        .clk(clk), .rst(rst), .mode(mode), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
        .done(done), .nack_err(nack_err), .scl_o(scl_o),
        .sda_o(sda_o), .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int ndone  = 0;

    always @(posedge clk) if (done) ndone++;

    // Slave model: ACKs written bytes, serves rdval after a read address byte
    logic       slave_on = 1'b1;
    logic [7:0] rdval = 8'h00;
    int         nk_lo = -1;
    int         nk_hi = -2;
    logic       pscl = 1'b1, psda = 1'b1, skipfall = 1'b0, rd = 1'b0, last_mack = 1'b0;
    int         bitcnt = 0, bytn = 0, nrise = 0, nstarts = 0, nstops = 0, blog_n = 0;
    logic [7:0] sh = 8'h00;
    logic [7:0] blog [0:255];
    time        t_rise = 0, per_last = 0;

    always @(scl_o or sda_o) begin
        if (scl_o && pscl && psda && !sda_o) begin
            nstarts++;
            bitcnt = 0; bytn = 0; rd = 1'b0; skipfall = 1'b1; slv_sda = 1'b1;
        end else if (scl_o && pscl && !psda && sda_o) begin
            nstops++;
            rd = 1'b0; slv_sda = 1'b1;
        end else if (scl_o && !pscl) begin
            nrise++;
            if (bitcnt >= 1 && bitcnt <= 8) per_last = $time - t_rise;
            t_rise = $time;
            if (bitcnt < 8) begin
                sh = {sh[6:0], sda_i};
                if (bitcnt == 7) begin
                    blog[8'(blog_n)] = sh;
                    blog_n++;
                    if (bytn == 0) rd = sh[0];
                end
            end else if (rd && bytn > 0) begin
                last_mack = sda_i;
                if (sda_i) rd = 1'b0;
            end
        end else if (!scl_o && pscl) begin
            if (skipfall) skipfall = 1'b0;
            else begin
                bitcnt++;
                if (bitcnt == 9) begin
                    bitcnt = 0;
                    bytn++;
                end
            end
            if (rd && bytn > 0)
                slv_sda = (bitcnt < 8) ? rdval[3'(7 - bitcnt)] : 1'b1;
            else
                slv_sda = !(bitcnt == 8 && slave_on &&
                            !(bytn == 0 && nstarts >= nk_lo && nstarts <= nk_hi));
        end
        pscl = scl_o;
        psda = sda_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] m, input logic w, input logic [12:0] a,
                         input logic [7:0] d);
        @(negedge clk);
        mode = m; we = w; addr = a; wdata = d; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic ok;
        int   b, s, d, r, f0;

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("idle_scl", 32'(scl_o), 32'd1);
        chk("idle_sda", 32'(sda_o), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_rdata", 32'(rdata), 32'd0);

        b = blog_n; s = nstops; d = ndone;
        issue(2'd0, 1'b1, 13'h15, 8'hA5);
        wait_done(ok);
        chk("m0w_done", 32'(ok), 32'd1);
        chk("m0w_busy", 32'(busy), 32'd0);
        chk("m0w_nack", 32'(nack_err), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("m0w_b0", 32'(blog[8'(b)]), 32'h2A);
        chk("m0w_b1", 32'(blog[8'(b + 1)]), 32'hA5);
`ifdef I2C_ACK_POLL_EN
        chk("m0w_stops", 32'(nstops - s), 32'd2);
`else
        chk("m0w_stops", 32'(nstops - s), 32'd1);
`endif
        chk("m0w_ndone", 32'(ndone - d), 32'd1);

        b = blog_n; s = nstarts; rdval = 8'h5E;
        issue(2'd1, 1'b0, 13'h2C3, 8'h00);
        wait_done(ok);
        chk("m1r_done", 32'(ok), 32'd1);
        chk("m1r_rdata", 32'(rdata), 32'h5E);
        chk("m1r_nack", 32'(nack_err), 32'd0);
        chk("m1r_b0", 32'(blog[8'(b)]), 32'hA4);
        chk("m1r_b1", 32'(blog[8'(b + 1)]), 32'hC3);
        chk("m1r_b2", 32'(blog[8'(b + 2)]), 32'hA5);
        chk("m1r_b3", 32'(blog[8'(b + 3)]), 32'h5E);
        chk("m1r_starts", 32'(nstarts - s), 32'd2);
        chk("m1r_mnack", 32'(last_mack), 32'd1);

        b = blog_n;
        issue(2'd2, 1'b1, 13'h1ABC, 8'h00);
        wait_done(ok);
        chk("m2w_done", 32'(ok), 32'd1);
        chk("m2w_nack", 32'(nack_err), 32'd0);
        chk("m2w_b0", 32'(blog[8'(b)]), 32'hA0);
        chk("m2w_b1", 32'(blog[8'(b + 1)]), 32'h1A);
        chk("m2w_b2", 32'(blog[8'(b + 2)]), 32'hBC);
        chk("m2w_b3", 32'(blog[8'(b + 3)]), 32'h00);
        chk("m2w_sclper", 32'(per_last), 32'(4 * CLK_DIV * 10));

        slave_on = 1'b0;
        b = blog_n; s = nstops; r = nrise;
        issue(2'd1, 1'b0, 13'h2C3, 8'h00);
        wait_done(ok);
        chk("nos_done", 32'(ok), 32'd1);
        chk("nos_nack", 32'(nack_err), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("nos_bits", 32'(nrise - r), 32'd10);
        chk("nos_stops", 32'(nstops - s), 32'd1);
        chk("nos_bytes", 32'(blog_n - b), 32'd1);
        chk("nos_held", 32'(nack_err), 32'd1);
        slave_on = 1'b1;

        b = blog_n; d = ndone; rdval = 8'h3C;
        issue(2'd1, 1'b0, 13'h2C3, 8'h00);
        chk("rst_nackclr", 32'(nack_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        repeat (200) @(posedge clk);
        issue(2'd0, 1'b1, 13'h7F, 8'hFF);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            if (blog_n >= b + 3) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_reach_rd", 32'(ok), 32'd1);
        repeat (3 * 4 * CLK_DIV) @(posedge clk);
        #1;
        chk("rst_b0", 32'(blog[8'(b)]), 32'hA4);
        chk("rst_b1", 32'(blog[8'(b + 1)]), 32'hC3);
        chk("rst_b2", 32'(blog[8'(b + 2)]), 32'hA5);
        chk("rst_nodone", 32'(ndone - d), 32'd0);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("rst_scl", 32'(scl_o), 32'd1);
        chk("rst_sda", 32'(sda_o), 32'd1);
        chk("rst_busy0", 32'(busy), 32'd0);
        chk("rst_done0", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_scl", 32'(scl_o), 32'd1);

`ifdef I2C_ACK_POLL_EN
        f0 = nstarts; d = ndone;
        nk_lo = f0 + 2;
        nk_hi = f0 + 4;
        issue(2'd2, 1'b1, 13'h0010, 8'h77);
        wait_done(ok);
        chk("poll_done", 32'(ok), 32'd1);
        chk("poll_nack", 32'(nack_err), 32'd0);
        repeat (20) @(posedge clk);
        chk("poll_frames", 32'(nstarts - f0), 32'd5);
        chk("poll_ndone", 32'(ndone - d), 32'd1);
`else
        f0 = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
